avg_unpool_stream: RTL and testbench

Streaming 2×2 average-unpooling (upsampling) stage for the CNN datapath. Consumes a raster-ordered IN_H×IN_W feature map one sample per handshake and emits a 2·IN_H×2·IN_W raster map. Each input value, divided by 4 via arithmetic shift, is replicated into its 2×2 output block. It is the inverse-direction partner of the 28×28→14×14 average pool: it redistributes a pooled map, or its gradient, back to full resolution.

---
 rtl/avg_unpool_stream.sv | 153 +++++++++++++++
 tb/tb_avg_unpool_stream.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/avg_unpool_stream.sv
// avg_unpool_stream
//   Streaming 2x2 average-unpooling stage. Takes a raster-ordered IN_H x IN_W
//   map, one sample per handshake. It emits a raster-ordered 2*IN_H x 2*IN_W
//   map. Each input sample is arithmetically shifted right by SCALE_SHIFT and
//   then replicated into its 2x2 output block.
//
//   Even output rows emit each incoming sample twice and capture it in a line
//   buffer. Odd output rows accept no input; they replay the line buffer, with
//   each entry emitted twice.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   input sample valid
//   in_ready   block accepts input this cycle
//   in_data    signed input sample (raster order)
//   out_valid  output sample valid
//   out_ready  downstream accepts output
//   out_data   signed output sample (raster order)
//   out_last   final output sample of a frame
module avg_unpool_stream #(
   parameter int IN_W        = 14,
   parameter int IN_H        = 14,
   parameter int DATA_W      = 16,
   parameter int SCALE_SHIFT = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last
);

   localparam int COL_W = (IN_W > 1) ? $clog2(IN_W) : 1;
   localparam int ROW_W = $clog2(2 * IN_H);

   localparam logic [COL_W-1:0] COL_LAST = COL_W'(IN_W - 1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(2 * IN_H - 1);

   typedef enum logic {
      EVEN = 1'b0,
      ODD  = 1'b1
   } state_e;

   state_e            state_q, state_d;
   logic [COL_W-1:0]  col_q, col_d;
   logic              dup_q, dup_d;
   logic [ROW_W-1:0]  orow_q, orow_d;
   logic              hold_valid_q, hold_valid_d;
   logic [DATA_W-1:0] hold_data_q, hold_data_d;
   logic [DATA_W-1:0] lb_q [IN_W];
   logic [DATA_W-1:0] lb_d [IN_W];

   logic [DATA_W-1:0] s_val;
   logic [COL_W-1:0]  col_inc;
   logic              xfer;
   logic              last_col;
   logic              in_ready_c;
   logic              accept;

   always_comb begin
      s_val    = DATA_W'($signed(in_data) >>> SCALE_SHIFT);
      col_inc  = col_q + COL_W'(1);
      xfer     = hold_valid_q && out_ready;
      last_col = (col_q == COL_LAST);
      // A sample is taken only when it can be the next thing held. At the
      // last column of an even row, the next output comes from the line
      // buffer, so input is refused there and no sample is lost.
      in_ready_c = !rst && (state_q == EVEN) &&
                   (!hold_valid_q || (xfer && dup_q && !last_col));
      accept   = in_valid && in_ready_c;
   end

   always_comb begin
      state_d      = state_q;
      col_d        = col_q;
      dup_d        = dup_q;
      orow_d       = orow_q;
      hold_valid_d = hold_valid_q;
      hold_data_d  = hold_data_q;
      lb_d         = lb_q;

      if (xfer) begin
         if (!dup_q) begin
            dup_d = 1'b1;
         end else begin
            dup_d = 1'b0;
            if (last_col) begin
               col_d  = '0;
               orow_d = (orow_q == ROW_LAST) ? '0 : orow_q + ROW_W'(1);
               if (state_q == EVEN) begin
                  // The whole row is now buffered; start replaying it.
                  state_d      = ODD;
                  hold_valid_d = 1'b1;
                  hold_data_d  = lb_q[0];
               end else begin
                  state_d      = EVEN;
                  hold_valid_d = 1'b0;
               end
            end else begin
               col_d = col_inc;
               if (state_q == ODD) begin
                  hold_data_d = lb_q[col_inc];
               end else begin
                  hold_valid_d = 1'b0;
               end
            end
         end
      end

      // col_d already points at the column this new sample occupies.
      if (accept) begin
         hold_valid_d = 1'b1;
         hold_data_d  = s_val;
         dup_d        = 1'b0;
         lb_d[col_d]  = s_val;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= EVEN;
         col_q        <= '0;
         dup_q        <= 1'b0;
         orow_q       <= '0;
         hold_valid_q <= 1'b0;
         hold_data_q  <= '0;
      end else begin
         state_q      <= state_d;
         col_q        <= col_d;
         dup_q        <= dup_d;
         orow_q       <= orow_d;
         hold_valid_q <= hold_valid_d;
         hold_data_q  <= hold_data_d;
      end
   end

   // The line buffer is only read after it is written within the same
   // frame, so it needs no reset.
   always_ff @(posedge clk) begin
      lb_q <= lb_d;
   end

   assign in_ready  = in_ready_c;
   assign out_valid = hold_valid_q;
   assign out_data  = hold_data_q;
   assign out_last  = (orow_q == ROW_LAST) && last_col && dup_q && hold_valid_q;

endmodule

// File: tb/tb_avg_unpool_stream.sv
module tb_avg_unpool_stream;

   localparam int IW   = 14;
   localparam int IH   = 14;
   localparam int NPIX = IW * IH;
   localparam int NOUT = 4 * NPIX;

   typedef struct {
      logic [15:0] data;
      bit          last;
   } exp_t;

   typedef struct {
      logic [15:0] din;
      logic [15:0] dexp;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid  [2];
   logic        in_ready  [2];
   logic [15:0] in_data   [2];
   logic        out_valid [2];
   logic        out_ready [2];
   logic [15:0] out_data  [2];
   logic        out_last  [2];

   always #5 clk = ~clk;

   avg_unpool_stream #(.IN_W(IW), .IN_H(IH), .DATA_W(16), .SCALE_SHIFT(2)) u_dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
      .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
      .out_last(out_last[0])
   );

   avg_unpool_stream #(.IN_W(IW), .IN_H(IH), .DATA_W(16), .SCALE_SHIFT(0)) u_dut_s0 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
      .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
      .out_last(out_last[1])
   );

   int          checks = 0;
   int          errors = 0;
   exp_t        exp_q    [2][$];
   logic [15:0] in_vals  [2][$];
   logic [15:0] exp_vals [2][$];
   logic [15:0] rowbuf   [2][IW];
   int          k        [2];
   int          nout     [2];
   int          last_cnt [2];
   bit          prev_stall [2];
   logic [15:0] prev_data  [2];
   int          gap_pct = 0;
   int          bp_pct  = 0;

   task automatic chk(input bit ok, input string name, input logic [31:0] act,
                      input logic [31:0] req);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Each accepted sample yields two copies in its even row. The last
   // sample of a row also releases the whole odd row that replays it.
   task automatic push_expected(input int d, input int kk);
      int p;
      int r;
      int c;
      logic [15:0] e;
      p = kk % NPIX;
      r = p / IW;
      c = p % IW;
      e = exp_vals[d][kk];
      exp_q[d].push_back('{data: e, last: 1'b0});
      exp_q[d].push_back('{data: e, last: 1'b0});
      rowbuf[d][c] = e;
      if (c == IW - 1) begin
         for (int j = 0; j < 2 * IW; j++)
            exp_q[d].push_back('{data: rowbuf[d][j/2], last: (r == IH - 1) && (j == 2 * IW - 1)});
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
         if (k[d] < in_vals[d].size() && int'($urandom_range(99)) >= gap_pct) begin
            in_valid[d] = 1'b1;
            in_data[d]  = in_vals[d][k[d]];
         end else begin
            in_valid[d] = 1'b0;
         end
         out_ready[d] = (int'($urandom_range(99)) >= bp_pct);
      end
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         int idx;
         if (prev_stall[d])
            chk(out_valid[d] === 1'b1 && out_data[d] === prev_data[d], "stall_hold",
                32'(out_data[d]), 32'(prev_data[d]));
         if (exp_q[d].size() == 0)
            chk(out_valid[d] === 1'b0, "idle_valid", 32'(out_valid[d]), 0);
         idx = nout[d] % NOUT;
         if (((idx / (2 * IW)) % 2) == 1)
            chk(in_ready[d] === 1'b0, "odd_in_ready", 32'(in_ready[d]), 0);
         if (in_valid[d] && in_ready[d]) begin
            push_expected(d, k[d]);
            k[d]++;
         end
         if (out_valid[d] && out_ready[d]) begin
            if (exp_q[d].size() > 0) begin
               exp_t e;
               e = exp_q[d].pop_front();
               chk(out_data[d] === e.data, "out_data", 32'(out_data[d]), 32'(e.data));
               chk(out_last[d] === e.last, "out_last", 32'(out_last[d]), 32'(e.last));
            end
            if (out_last[d]) last_cnt[d]++;
            nout[d]++;
         end
         prev_stall[d] = out_valid[d] && !out_ready[d];
         prev_data[d]  = out_data[d];
      end
   endtask

   task automatic clear_vals(input int d);
      in_vals[d].delete();
      exp_vals[d].delete();
      k[d] = 0;
   endtask

   task automatic load_ramp(input int d);
      clear_vals(d);
      for (int i = 0; i < NPIX; i++) begin
         in_vals[d].push_back(16'(4 * i));
         exp_vals[d].push_back(16'(i));
      end
   endtask

   task automatic run(input string name, input int budget, input int stop_out0);
      int cyc;
      bit done;
      cyc  = 0;
      done = 1'b0;
      while (!done && cyc < budget) begin
         cycle();
         cyc++;
         done = 1'b1;
         for (int d = 0; d < 2; d++)
            if (k[d] < in_vals[d].size() || exp_q[d].size() != 0) done = 1'b0;
         if (stop_out0 > 0 && nout[0] >= stop_out0) done = 1'b1;
      end
      if (!done) chk(1'b0, {name, "_timeout"}, 32'(cyc), 32'(budget));
   endtask

   initial begin
      vec_t tbl [8];
      tbl[0] = '{din: 16'hFFFD, dexp: 16'hFFFF};  // -3 -> -1
      tbl[1] = '{din: 16'hFFFC, dexp: 16'hFFFF};  // -4 -> -1
      tbl[2] = '{din: 16'h0007, dexp: 16'h0001};
      tbl[3] = '{din: 16'h7FFF, dexp: 16'h1FFF};
      tbl[4] = '{din: 16'h8000, dexp: 16'hE000};
      tbl[5] = '{din: 16'hFFFF, dexp: 16'hFFFF};
      tbl[6] = '{din: 16'h0003, dexp: 16'h0000};
      tbl[7] = '{din: 16'hFFF8, dexp: 16'hFFFE};

      for (int d = 0; d < 2; d++) begin
         in_valid[d] = 1'b0; in_data[d] = '0; out_ready[d] = 1'b0;
         k[d] = 0; nout[d] = 0; last_cnt[d] = 0; prev_stall[d] = 1'b0; prev_data[d] = '0;
      end

      // Reset state
      rst = 1'b1;
      repeat (2) @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         chk(out_valid[d] === 1'b0, "rst_out_valid", 32'(out_valid[d]), 0);
         chk(out_data[d] === 16'h0, "rst_out_data", 32'(out_data[d]), 0);
         chk(out_last[d] === 1'b0, "rst_out_last", 32'(out_last[d]), 0);
         chk(in_ready[d] === 1'b0, "rst_in_ready", 32'(in_ready[d]), 0);
      end
      @(posedge clk); #1; rst = 1'b0;
      @(negedge clk);
      for (int d = 0; d < 2; d++)
         chk(in_ready[d] === 1'b1, "post_rst_in_ready", 32'(in_ready[d]), 1);

      // Ramp, free-flowing
      load_ramp(0); clear_vals(1); gap_pct = 0; bp_pct = 0;
      run("ramp", 5000, 0);
      chk(last_cnt[0] == 1, "ramp_last_count", 32'(last_cnt[0]), 1);

      // Sign and rounding, table-driven samples at the start of a frame
      clear_vals(0);
      for (int i = 0; i < NPIX; i++) begin
         if (i < 8) begin
            in_vals[0].push_back(tbl[i].din);
            exp_vals[0].push_back(tbl[i].dexp);
         end else begin
            in_vals[0].push_back(16'h0000);
            exp_vals[0].push_back(16'h0000);
         end
      end
      run("sign", 5000, 0);

      // Backpressure
      load_ramp(0); gap_pct = 0; bp_pct = 50;
      run("backpressure", 10000, 0);

      // Input starvation
      load_ramp(0); gap_pct = 50; bp_pct = 0;
      run("starve", 10000, 0);

      // Reset in the middle of a frame
      load_ramp(0); gap_pct = 0; bp_pct = 0;
      run("pre_reset", 5000, 100);
      #2 rst = 1'b1;
      #1;
      chk(out_valid[0] === 1'b0, "midrst_out_valid", 32'(out_valid[0]), 0);
      chk(in_ready[0] === 1'b0, "midrst_in_ready", 32'(in_ready[0]), 0);
      chk(out_last[0] === 1'b0, "midrst_out_last", 32'(out_last[0]), 0);
      for (int d = 0; d < 2; d++) begin
         in_valid[d] = 1'b0;
         exp_q[d].delete();
         clear_vals(d);
         nout[d] = 0;
         prev_stall[d] = 1'b0;
      end
      @(posedge clk); #1; rst = 1'b0;
      load_ramp(0); last_cnt[0] = 0;
      run("post_reset", 5000, 0);
      chk(last_cnt[0] == 1, "post_reset_last_count", 32'(last_cnt[0]), 1);

      // No scaling, two back-to-back frames of random samples
      clear_vals(0); clear_vals(1); gap_pct = 0; bp_pct = 0;
      for (int i = 0; i < 2 * NPIX; i++) begin
         logic [15:0] v;
         v = 16'($urandom);
         in_vals[1].push_back(v);
         exp_vals[1].push_back(v);
      end
      last_cnt[1] = 0;
      run("noscale", 10000, 0);
      chk(last_cnt[1] == 2, "noscale_last_count", 32'(last_cnt[1]), 2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
